cross_filter5: RTL and testbench

- Downstream consumer of the 5-pixel cross-neighbourhood line-buffer stage (px1 up, px2 left, px3 centre, px4 right, px5 down).
- Applies a selectable rank-order filter per pixel: median (denoise), minimum (erosion) or maximum (dilation), or bypass.
- Pipelined compare-exchange network; frame-border pixels pass the centre value through unfiltered.
- Output drives the VGA display / frame-buffer write path.

---
 rtl/cross_filter5.sv | 151 +++++++++++++++
 tb/tb_cross_filter5.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cross_filter5.sv
// Rank-order filter over a 5-pixel cross neighbourhood: median, min, max or bypass.
// Four registered stages; frame-border pixels pass the centre value through.
module cross_filter5 #(
    parameter int ROW = 480,
    parameter int COL = 640,
    parameter int DW  = 8,
    parameter int LAT = 4
) (
    input  logic          vga_clk,
    input  logic          rst,
    input  logic [DW-1:0] px1,
    input  logic [DW-1:0] px2,
    input  logic [DW-1:0] px3,
    input  logic [DW-1:0] px4,
    input  logic [DW-1:0] px5,
    input  logic          px_vld,
    input  logic [1:0]    mode,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          dout_sof,
    output logic          dout_eof
);

    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);

    typedef struct packed {
        logic       border;
        logic       sof;
        logic       eof;
        logic [1:0] mode;
    } tag_t;

    logic [RW-1:0]  row_cnt;
    logic [CW-1:0]  col_cnt;
    logic [1:0]     mode_q;
    logic [LAT-1:0] vld_sr;
    logic           frame_start;
    tag_t           tag_in;

    logic [DW-1:0] s1_p1, s1_p2, s1_p3, s1_p4, s1_p5;
    tag_t          s1_tag;
    logic [DW-1:0] s2_lo_a, s2_hi_a, s2_lo_b, s2_hi_b, s2_c;
    tag_t          s2_tag;
    logic [DW-1:0] s3_mn, s3_mx, s3_md, s3_c;
    tag_t          s3_tag;
    logic [DW-1:0] sel;

    function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    assign frame_start = (row_cnt == '0) && (col_cnt == '0);

    always_comb begin
        tag_in        = '0;
        tag_in.border = (row_cnt == '0) || (row_cnt == ROW_LAST) ||
                        (col_cnt == '0) || (col_cnt == COL_LAST);
        tag_in.sof    = frame_start;
        tag_in.eof    = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
        tag_in.mode   = frame_start ? mode : mode_q;
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            row_cnt <= '0;
            col_cnt <= '0;
            mode_q  <= 2'd0;
            vld_sr  <= '0;
        end else begin
            vld_sr <= {vld_sr[LAT-2:0], px_vld};
            if (px_vld) begin
                if (frame_start)
                    mode_q <= mode;
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

    // Data stages carry no reset; they only load when their valid bit is set.
    always_ff @(posedge vga_clk) begin
        if (px_vld) begin
            s1_p1  <= px1;
            s1_p2  <= px2;
            s1_p3  <= px3;
            s1_p4  <= px4;
            s1_p5  <= px5;
            s1_tag <= tag_in;
        end
        if (vld_sr[0]) begin
            s2_lo_a <= min2(s1_p1, s1_p2);
            s2_hi_a <= max2(s1_p1, s1_p2);
            s2_lo_b <= min2(s1_p4, s1_p5);
            s2_hi_b <= max2(s1_p4, s1_p5);
            s2_c    <= s1_p3;
            s2_tag  <= s1_tag;
        end
        // min of the two lows and max of the two highs cannot be the median
        if (vld_sr[1]) begin
            s3_mn  <= min2(min2(s2_lo_a, s2_lo_b), s2_c);
            s3_mx  <= max2(max2(s2_hi_a, s2_hi_b), s2_c);
            s3_md  <= med3(max2(s2_lo_a, s2_lo_b), min2(s2_hi_a, s2_hi_b), s2_c);
            s3_c   <= s2_c;
            s3_tag <= s2_tag;
        end
    end

    always_comb begin
        sel = s3_c;
        if (!s3_tag.border) begin
            case (s3_tag.mode)
                2'd0:    sel = s3_md;
                2'd1:    sel = s3_mn;
                2'd2:    sel = s3_mx;
                default: sel = s3_c;
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            dout     <= '0;
            dout_sof <= 1'b0;
            dout_eof <= 1'b0;
        end else begin
            dout_sof <= vld_sr[2] & s3_tag.sof;
            dout_eof <= vld_sr[2] & s3_tag.eof;
            if (vld_sr[2])
                dout <= sel;
        end
    end

    assign dout_vld = vld_sr[LAT-1];

endmodule

// File: tb/tb_cross_filter5.sv
// Directed bench for cross_filter5 on an 8x8 frame.
// Output beats are logged and compared against a sort-based reference.
module tb_cross_filter5;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int NPX = ROW * COL;

    logic       vga_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] px1 = '0, px2 = '0, px3 = '0, px4 = '0, px5 = '0;
    logic       px_vld = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] dout;
    logic       dout_vld, dout_sof, dout_eof;

    cross_filter5 #(.ROW(ROW), .COL(COL), .DW(8), .LAT(4)) dut (
        .vga_clk (vga_clk),
        .rst     (rst),
        .px1     (px1),
        .px2     (px2),
        .px3     (px3),
        .px4     (px4),
        .px5     (px5),
        .px_vld  (px_vld),
        .mode    (mode),
        .dout    (dout),
        .dout_vld(dout_vld),
        .dout_sof(dout_sof),
        .dout_eof(dout_eof)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_d[$];
    logic       exp_sof[$], exp_eof[$];
    int         exp_cyc[$];
    logic [7:0] got_d[$];
    logic       got_sof[$], got_eof[$];
    int         got_cyc[$];

    always @(negedge vga_clk) begin
        if (dout_vld) begin
            got_d.push_back(dout);
            got_sof.push_back(dout_sof);
            got_eof.push_back(dout_eof);
            got_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] pix(input int f, input int r, input int c, input int i);
        logic [7:0] d33[5];
        logic [7:0] d55[5];
        d33 = '{8'd10, 8'd50, 8'd30, 8'd20, 8'd40};
        d55 = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd128};
        if (r == 3 && c == 3) return d33[i];
        if (r == 5 && c == 5) return d55[i];
        if ((r == 0 && c == 5) || (r == 7 && c == 7) || (r == 4 && c == 0))
            return (i == 2) ? 8'd77 : 8'd0;
        return 8'((r * 37 + c * 11 + i * 53 + f * 29 + i * i * 7) & 255);
    endfunction

    function automatic logic [7:0] model(input logic [7:0] v[5], input logic [1:0] m,
                                         input int r, input int c);
        logic [7:0] s[5];
        logic [7:0] t;
        s = v;
        for (int a = 0; a < 5; a++)
            for (int b = 0; b < 4 - a; b++)
                if (s[b] > s[b+1]) begin
                    t = s[b]; s[b] = s[b+1]; s[b+1] = t;
                end
        if (r == 0 || r == ROW - 1 || c == 0 || c == COL - 1 || m == 2'd3) return v[2];
        if (m == 2'd0) return s[2];
        if (m == 2'd1) return s[0];
        return s[4];
    endfunction

    task automatic run_frame(input int f, input logic [1:0] m, input int gap,
                             input int sw, input logic [1:0] m2, input int n);
        logic [7:0] v[5];
        int r, c;
        for (int k = 0; k < n; k++) begin
            r = k / COL;
            c = k % COL;
            if (k == 0) mode = m;
            if (k == sw) mode = m2;
            for (int i = 0; i < 5; i++) v[i] = pix(f, r, c, i);
            px1 = v[0]; px2 = v[1]; px3 = v[2]; px4 = v[3]; px5 = v[4];
            px_vld = 1'b1;
            exp_d.push_back(model(v, m, r, c));
            exp_sof.push_back(k == 0);
            exp_eof.push_back(k == NPX - 1);
            exp_cyc.push_back(cyc);
            @(posedge vga_clk);
            #1;
            px_vld = 1'b0;
            repeat (gap) begin
                @(posedge vga_clk);
                #1;
            end
        end
    endtask

    task automatic settle();
        repeat (8) @(posedge vga_clk);
        #1;
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got_d.size()) return 32'(got_d[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic compare_all(input string tag);
        int n;
        chk({tag, " count"}, got_d.size(), exp_d.size());
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s dout[%0d]", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s sof[%0d]", tag, i), got_sof[i], exp_sof[i]);
            chk($sformatf("%s eof[%0d]", tag, i), got_eof[i], exp_eof[i]);
            chk($sformatf("%s lat[%0d]", tag, i), got_cyc[i] - exp_cyc[i], 4);
        end
        exp_d.delete(); exp_sof.delete(); exp_eof.delete(); exp_cyc.delete();
        got_d.delete(); got_sof.delete(); got_eof.delete(); got_cyc.delete();
    endtask

    initial begin
        repeat (3) @(posedge vga_clk);
        #1;
        chk("reset dout", dout, 0);
        chk("reset vld", dout_vld, 0);
        chk("reset sof", dout_sof, 0);
        chk("reset eof", dout_eof, 0);
        rst = 1'b0;
        @(posedge vga_clk);
        #1;

        run_frame(1, 2'd0, 0, -1, 2'd0, NPX);
        settle();
        chk("median 3,3", got_at(27), 30);
        chk("border 0,5", got_at(5), 77);
        chk("border 7,7", got_at(63), 77);
        chk("border 4,0", got_at(32), 77);
        chk("median 5,5", got_at(45), 128);
        compare_all("f1");

        run_frame(2, 2'd1, 0, -1, 2'd1, NPX);
        settle();
        chk("min 3,3", got_at(27), 10);
        chk("min 5,5", got_at(45), 0);
        chk("min border 0,5", got_at(5), 77);
        compare_all("f2");

        run_frame(3, 2'd2, 0, 18, 2'd0, NPX);
        settle();
        chk("latched max 3,3", got_at(27), 50);
        chk("latched max 5,5", got_at(45), 255);
        compare_all("f3");

        run_frame(4, 2'd0, 0, -1, 2'd0, NPX);
        settle();
        chk("relatch median 3,3", got_at(27), 30);
        compare_all("f4");

        run_frame(5, 2'd3, 1, -1, 2'd3, NPX);
        run_frame(6, 2'd2, 0, -1, 2'd2, NPX);
        settle();
        chk("bypass 3,3", got_at(27), 30);
        chk("bypass 5,5", got_at(45), 255);
        chk("gappy sof first", got_sof.size() > 0 ? got_sof[0] : 1'bx, 1);
        chk("gappy eof 64th", got_eof.size() > 63 ? got_eof[63] : 1'bx, 1);
        chk("wrap sof 65th", got_sof.size() > 64 ? got_sof[64] : 1'bx, 1);
        chk("next max 3,3", got_at(NPX + 27), 50);
        compare_all("f5f6");

        run_frame(7, 2'd0, 0, -1, 2'd0, 35);
        rst = 1'b1;
        @(posedge vga_clk);
        #1;
        rst = 1'b0;
        chk("midrst dout", dout, 0);
        chk("midrst vld", dout_vld, 0);
        chk("midrst sof", dout_sof, 0);
        chk("midrst eof", dout_eof, 0);
        repeat (3) begin
            void'(exp_d.pop_back());
            void'(exp_sof.pop_back());
            void'(exp_eof.pop_back());
            void'(exp_cyc.pop_back());
        end
        settle();
        compare_all("f7");

        run_frame(8, 2'd1, 0, -1, 2'd1, NPX);
        settle();
        chk("post-reset sof", got_sof.size() > 0 ? got_sof[0] : 1'bx, 1);
        chk("post-reset min 3,3", got_at(27), 10);
        compare_all("f8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
